// File: rtl/fwnoc_pkg.sv
// Shared definitions for the fwnoc host endpoint.
// Holds the header flit layout, the header pack/unpack helpers and the
// TX/RX state encodings used by fwnoc_host_ep and fwnoc_host_ep_rx.
package fwnoc_pkg;

  localparam int unsigned FLIT_W    = 32;
  localparam int unsigned DST_X_LSB = 0;
  localparam int unsigned DST_Y_LSB = 2;
  localparam int unsigned SRC_X_LSB = 4;
  localparam int unsigned SRC_Y_LSB = 6;
  localparam int unsigned LEN_LSB   = 8;
  localparam int unsigned TAG_LSB   = 16;
  localparam int unsigned COORD_W   = 2;
  localparam int unsigned LEN_W     = 8;
  localparam int unsigned TAG_W     = 16;

  typedef struct packed {
    logic [TAG_W-1:0]   tag;
    logic [LEN_W-1:0]   len;
    logic [COORD_W-1:0] src_y;
    logic [COORD_W-1:0] src_x;
    logic [COORD_W-1:0] dst_y;
    logic [COORD_W-1:0] dst_x;
  } fwnoc_hdr_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_HDR,
    TX_DATA
  } tx_state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_HDR,
    RX_DATA,
    RX_DROP
  } rx_state_e;

  function automatic logic [FLIT_W-1:0] hdr_pack(input fwnoc_hdr_t h);
    logic [FLIT_W-1:0] f;
    f = '0;
    f[DST_X_LSB +: COORD_W] = h.dst_x;
    f[DST_Y_LSB +: COORD_W] = h.dst_y;
    f[SRC_X_LSB +: COORD_W] = h.src_x;
    f[SRC_Y_LSB +: COORD_W] = h.src_y;
    f[LEN_LSB   +: LEN_W]   = h.len;
    f[TAG_LSB   +: TAG_W]   = h.tag;
    return f;
  endfunction

  function automatic fwnoc_hdr_t hdr_unpack(input logic [FLIT_W-1:0] f);
    fwnoc_hdr_t h;
    h.dst_x = f[DST_X_LSB +: COORD_W];
    h.dst_y = f[DST_Y_LSB +: COORD_W];
    h.src_x = f[SRC_X_LSB +: COORD_W];
    h.src_y = f[SRC_Y_LSB +: COORD_W];
    h.len   = f[LEN_LSB   +: LEN_W];
    h.tag   = f[TAG_LSB   +: TAG_W];
    return h;
  endfunction

endpackage

// File: rtl/fwnoc_host_ep_rx.sv
// RX parser for the fwnoc host endpoint.
// Accepts flits from the router he_ port, presents matching packets as a
// header record (rxh_*) followed by a payload stream (rxd_*), and silently
// consumes packets addressed to another node while counting them.
// Ports: clock/reset (async active-low); net_i_* flit input; rxh_* header
// output; rxd_* payload output; drop_cnt saturating misroute count.
module fwnoc_host_ep_rx
  import fwnoc_pkg::*;
#(
  parameter logic [1:0] X_ID = 2'd0,
  parameter logic [1:0] Y_ID = 2'd0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] net_i_dat,
  input  logic        net_i_valid,
  output logic        net_i_ready,
  output logic        rxh_valid,
  input  logic        rxh_ready,
  output logic [1:0]  rxh_src_x,
  output logic [1:0]  rxh_src_y,
  output logic [7:0]  rxh_len,
  output logic [15:0] rxh_tag,
  output logic [31:0] rxd_dat,
  output logic        rxd_valid,
  input  logic        rxd_ready,
  output logic        rxd_last,
  output logic [15:0] drop_cnt
);

  rx_state_e   state_q, state_d;
  logic [1:0]  src_x_q, src_x_d;
  logic [1:0]  src_y_q, src_y_d;
  logic [7:0]  len_q, len_d;
  logic [15:0] tag_q, tag_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] drop_q, drop_d;
  fwnoc_hdr_t  in_hdr;

  always_comb begin
    in_hdr      = hdr_unpack(net_i_dat);
    state_d     = state_q;
    src_x_d     = src_x_q;
    src_y_d     = src_y_q;
    len_d       = len_q;
    tag_d       = tag_q;
    cnt_d       = cnt_q;
    drop_d      = drop_q;
    net_i_ready = 1'b0;
    rxh_valid   = 1'b0;
    rxd_valid   = 1'b0;
    rxd_last    = 1'b0;
    rxd_dat     = '0;
    case (state_q)
      RX_IDLE: begin
        net_i_ready = 1'b1;
        if (net_i_valid) begin
          src_x_d = in_hdr.src_x;
          src_y_d = in_hdr.src_y;
          len_d   = in_hdr.len;
          tag_d   = in_hdr.tag;
          cnt_d   = in_hdr.len;
          if (in_hdr.dst_x == X_ID && in_hdr.dst_y == Y_ID) begin
            state_d = RX_HDR;
          end else begin
            if (drop_q != '1) drop_d = drop_q + 16'd1;
            state_d = (in_hdr.len != '0) ? RX_DROP : RX_IDLE;
          end
        end
      end
      RX_HDR: begin
        rxh_valid = 1'b1;
        if (rxh_ready) begin
          cnt_d   = len_q;
          state_d = (len_q == '0) ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        // Payload flows straight through; the sink's ready backpressures the router.
        net_i_ready = rxd_ready;
        rxd_valid   = net_i_valid;
        rxd_dat     = net_i_dat;
        rxd_last    = (cnt_q == 8'd1);
        if (net_i_valid && rxd_ready) begin
          cnt_d = cnt_q - 8'd1;
          if (cnt_q == 8'd1) state_d = RX_IDLE;
        end
      end
      RX_DROP: begin
        net_i_ready = 1'b1;
        if (net_i_valid) begin
          cnt_d = cnt_q - 8'd1;
          if (cnt_q == 8'd1) state_d = RX_IDLE;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= RX_IDLE;
      src_x_q <= '0;
      src_y_q <= '0;
      len_q   <= '0;
      tag_q   <= '0;
      cnt_q   <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      src_x_q <= src_x_d;
      src_y_q <= src_y_d;
      len_q   <= len_d;
      tag_q   <= tag_d;
      cnt_q   <= cnt_d;
      drop_q  <= drop_d;
    end
  end

  assign rxh_src_x = src_x_q;
  assign rxh_src_y = src_y_q;
  assign rxh_len   = len_q;
  assign rxh_tag   = tag_q;
  assign drop_cnt  = drop_q;

endmodule

// File: rtl/fwnoc_host_ep.sv
// Host-side endpoint for one fwnoc router node.
// TX: turns a send command plus a payload stream into a header flit followed
// by len payload flits on net_o (router hi_ port). RX: delegated to
// fwnoc_host_ep_rx, which parses net_i (router he_ port) flits.
// Ports: clock/reset (async active-low); cmd_* send command; txd_* TX
// payload; net_o_*/net_i_* router side; rxh_*/rxd_* RX outputs; drop_cnt.
module fwnoc_host_ep
  import fwnoc_pkg::*;
#(
  parameter logic [1:0] X_ID = 2'd0,
  parameter logic [1:0] Y_ID = 2'd0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_dst_x,
  input  logic [1:0]  cmd_dst_y,
  input  logic [7:0]  cmd_len,
  input  logic [15:0] cmd_tag,
  input  logic [31:0] txd_dat,
  input  logic        txd_valid,
  output logic        txd_ready,
  output logic [31:0] net_o_dat,
  output logic        net_o_valid,
  input  logic        net_o_ready,
  input  logic [31:0] net_i_dat,
  input  logic        net_i_valid,
  output logic        net_i_ready,
  output logic        rxh_valid,
  input  logic        rxh_ready,
  output logic [1:0]  rxh_src_x,
  output logic [1:0]  rxh_src_y,
  output logic [7:0]  rxh_len,
  output logic [15:0] rxh_tag,
  output logic [31:0] rxd_dat,
  output logic        rxd_valid,
  input  logic        rxd_ready,
  output logic        rxd_last,
  output logic [15:0] drop_cnt
);

  tx_state_e   tx_state_q, tx_state_d;
  logic [31:0] tx_hdr_q, tx_hdr_d;
  logic [7:0]  tx_cnt_q, tx_cnt_d;
  fwnoc_hdr_t  cmd_hdr;

  always_comb begin
    cmd_hdr.dst_x = cmd_dst_x;
    cmd_hdr.dst_y = cmd_dst_y;
    cmd_hdr.src_x = X_ID;
    cmd_hdr.src_y = Y_ID;
    cmd_hdr.len   = cmd_len;
    cmd_hdr.tag   = cmd_tag;
    tx_state_d    = tx_state_q;
    tx_hdr_d      = tx_hdr_q;
    tx_cnt_d      = tx_cnt_q;
    cmd_ready     = 1'b0;
    txd_ready     = 1'b0;
    net_o_valid   = 1'b0;
    net_o_dat     = '0;
    case (tx_state_q)
      TX_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          tx_hdr_d   = hdr_pack(cmd_hdr);
          tx_state_d = TX_HDR;
        end
      end
      TX_HDR: begin
        net_o_valid = 1'b1;
        net_o_dat   = tx_hdr_q;
        if (net_o_ready) begin
          tx_cnt_d   = tx_hdr_q[LEN_LSB +: LEN_W];
          tx_state_d = (tx_hdr_q[LEN_LSB +: LEN_W] == '0) ? TX_IDLE : TX_DATA;
        end
      end
      TX_DATA: begin
        net_o_valid = txd_valid;
        net_o_dat   = txd_dat;
        txd_ready   = net_o_ready;
        if (txd_valid && net_o_ready) begin
          tx_cnt_d = tx_cnt_q - 8'd1;
          if (tx_cnt_q == 8'd1) tx_state_d = TX_IDLE;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tx_state_q <= TX_IDLE;
      tx_hdr_q   <= '0;
      tx_cnt_q   <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_hdr_q   <= tx_hdr_d;
      tx_cnt_q   <= tx_cnt_d;
    end
  end

  fwnoc_host_ep_rx #(
    .X_ID(X_ID),
    .Y_ID(Y_ID)
  ) u_rx (
    .clock       (clock),
    .reset       (reset),
    .net_i_dat   (net_i_dat),
    .net_i_valid (net_i_valid),
    .net_i_ready (net_i_ready),
    .rxh_valid   (rxh_valid),
    .rxh_ready   (rxh_ready),
    .rxh_src_x   (rxh_src_x),
    .rxh_src_y   (rxh_src_y),
    .rxh_len     (rxh_len),
    .rxh_tag     (rxh_tag),
    .rxd_dat     (rxd_dat),
    .rxd_valid   (rxd_valid),
    .rxd_ready   (rxd_ready),
    .rxd_last    (rxd_last),
    .drop_cnt    (drop_cnt)
  );

endmodule

// File: tb/tb_fwnoc_host_ep.sv
// Bench for fwnoc_host_ep: queue-based reference model of packets, random
// handshake pressure, directed scenarios for header layout, zero-length
// packets, misroute drops, reset mid-packet and drop counter saturation.
module tb_fwnoc_host_ep;

  localparam logic [1:0] MY_X = 2'd2;
  localparam logic [1:0] MY_Y = 2'd1;

  logic        clock;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_dst_x;
  logic [1:0]  cmd_dst_y;
  logic [7:0]  cmd_len;
  logic [15:0] cmd_tag;
  logic [31:0] txd_dat;
  logic        txd_valid;
  logic        txd_ready;
  logic [31:0] net_o_dat;
  logic        net_o_valid;
  logic        net_o_ready;
  logic [31:0] net_i_dat;
  logic        net_i_valid;
  logic        net_i_ready;
  logic        rxh_valid;
  logic        rxh_ready;
  logic [1:0]  rxh_src_x;
  logic [1:0]  rxh_src_y;
  logic [7:0]  rxh_len;
  logic [15:0] rxh_tag;
  logic [31:0] rxd_dat;
  logic        rxd_valid;
  logic        rxd_ready;
  logic        rxd_last;
  logic [15:0] drop_cnt;

  fwnoc_host_ep #(.X_ID(MY_X), .Y_ID(MY_Y)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dst_x(cmd_dst_x),
    .cmd_dst_y(cmd_dst_y), .cmd_len(cmd_len), .cmd_tag(cmd_tag),
    .txd_dat(txd_dat), .txd_valid(txd_valid), .txd_ready(txd_ready),
    .net_o_dat(net_o_dat), .net_o_valid(net_o_valid), .net_o_ready(net_o_ready),
    .net_i_dat(net_i_dat), .net_i_valid(net_i_valid), .net_i_ready(net_i_ready),
    .rxh_valid(rxh_valid), .rxh_ready(rxh_ready), .rxh_src_x(rxh_src_x),
    .rxh_src_y(rxh_src_y), .rxh_len(rxh_len), .rxh_tag(rxh_tag),
    .rxd_dat(rxd_dat), .rxd_valid(rxd_valid), .rxd_ready(rxd_ready),
    .rxd_last(rxd_last), .drop_cnt(drop_cnt)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [31:0] exp_net[$];
  logic [31:0] txd_q[$];
  logic [31:0] ni_q[$];
  logic [31:0] net_log[$];
  logic [63:0] exp_rxh[$];
  logic [63:0] exp_rxd[$];
  logic [63:0] rxh_log[$];
  int model_drops = 0;
  int net_cnt = 0, txd_cnt = 0, ni_cnt = 0, rxd_cnt = 0, rxd_last_cnt = 0;
  bit txd_hs = 0, ni_hs = 0, rx_seen = 0;

  // Handshake pressure knobs: 0 random, 1 low, 2 high, 3 toggle
  int o_ready_mode = 2, rxh_mode = 2, rxd_mode = 2;
  int ni_gap = 0, td_gap = 0;

  function automatic logic [31:0] hdr_word(input int dx, input int dy, input int sx,
                                           input int sy, input int len, input int tag);
    int unsigned v;
    v = 32'(tag) * 65536 + 32'(len) * 256 + 32'(sy) * 64 + 32'(sx) * 16 + 32'(dy) * 4 + 32'(dx);
    return v;
  endfunction

  function automatic logic pick(input int mode, input logic cur);
    case (mode)
      1:       return 1'b0;
      2:       return 1'b1;
      3:       return !cur;
      default: return 1'($urandom_range(1));
    endcase
  endfunction

  function automatic logic [31:0] log_at(input int i);
    if (i < net_log.size()) return net_log[i];
    return 'x;
  endfunction

  // Sink-side ready drivers
  initial begin
    net_o_ready = 1'b0;
    rxh_ready   = 1'b0;
    rxd_ready   = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      net_o_ready = pick(o_ready_mode, net_o_ready);
      rxh_ready   = pick(rxh_mode, rxh_ready);
      rxd_ready   = pick(rxd_mode, rxd_ready);
    end
  end

  // TX payload source
  initial begin
    txd_valid = 1'b0;
    txd_dat   = '0;
    forever begin
      @(posedge clock);
      #1;
      if (txd_hs) begin
        if (txd_q.size() > 0) void'(txd_q.pop_front());
        txd_valid = 1'b0;
      end
      if (!txd_valid && txd_q.size() > 0 && $urandom_range(99) >= td_gap) begin
        txd_valid = 1'b1;
        txd_dat   = txd_q[0];
      end
    end
  end

  // Router-side flit source into net_i
  initial begin
    net_i_valid = 1'b0;
    net_i_dat   = '0;
    forever begin
      @(posedge clock);
      #1;
      if (ni_hs) begin
        if (ni_q.size() > 0) void'(ni_q.pop_front());
        net_i_valid = 1'b0;
      end
      if (!net_i_valid && ni_q.size() > 0 && $urandom_range(99) >= ni_gap) begin
        net_i_valid = 1'b1;
        net_i_dat   = ni_q[0];
      end
    end
  end

  // Monitor: observes handshakes mid-cycle, ahead of the edge that commits them
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clock);
      if (!reset) begin
        txd_hs = 0;
        ni_hs  = 0;
      end else begin
        txd_hs = txd_valid && txd_ready;
        ni_hs  = net_i_valid && net_i_ready;
        if (txd_hs) txd_cnt++;
        if (ni_hs) ni_cnt++;
        if (rxh_valid || rxd_valid) rx_seen = 1;
        if (net_o_valid && net_o_ready) begin
          net_cnt++;
          net_log.push_back(net_o_dat);
          check_val("net_o_expected", 64'(exp_net.size() > 0), 64'd1);
          if (exp_net.size() > 0) check_val("net_o_flit", 64'(net_o_dat), 64'(exp_net.pop_front()));
        end
        if (rxh_valid && rxh_ready) begin
          e = 64'({rxh_src_x, rxh_src_y, rxh_len, rxh_tag});
          rxh_log.push_back(e);
          check_val("rxh_expected", 64'(exp_rxh.size() > 0), 64'd1);
          if (exp_rxh.size() > 0) check_val("rxh_fields", e, exp_rxh.pop_front());
        end
        if (rxd_valid && rxd_ready) begin
          rxd_cnt++;
          if (rxd_last) rxd_last_cnt++;
          check_val("rxd_expected", 64'(exp_rxd.size() > 0), 64'd1);
          if (exp_rxd.size() > 0) check_val("rxd_word", 64'({rxd_last, rxd_dat}), exp_rxd.pop_front());
        end
      end
    end
  end

  task automatic send_cmd(input int dx, input int dy, input int len, input int tag);
    logic ok;
    ok = 1'b0;
    @(posedge clock);
    #1;
    cmd_valid = 1'b1;
    cmd_dst_x = 2'(dx);
    cmd_dst_y = 2'(dy);
    cmd_len   = 8'(len);
    cmd_tag   = 16'(tag);
    for (int i = 0; i < 2000; i++) begin
      @(negedge clock);
      ok = cmd_ready;
      @(posedge clock);
      #1;
      if (ok) break;
    end
    cmd_valid = 1'b0;
    check_val("cmd_accept", 64'(ok), 64'd1);
  endtask

  task automatic tx_pkt(input int dx, input int dy, input int len, input int tag,
                        input int supply, input bit fixed);
    logic [31:0] w;
    exp_net.push_back(hdr_word(dx, dy, MY_X, MY_Y, len, tag));
    for (int i = 0; i < len; i++) begin
      w = fixed ? 32'(17 * (i + 1)) : $urandom;
      exp_net.push_back(w);
      if (i < supply) txd_q.push_back(w);
    end
    send_cmd(dx, dy, len, tag);
  endtask

  task automatic rx_pkt(input int dx, input int dy, input int sx, input int sy,
                        input int len, input int tag);
    logic [31:0] w;
    bit match;
    match = (dx == int'(MY_X)) && (dy == int'(MY_Y));
    ni_q.push_back(hdr_word(dx, dy, sx, sy, len, tag));
    if (match)
      exp_rxh.push_back((64'(sx) << 26) | (64'(sy) << 24) | (64'(len) << 16) | 64'(tag));
    else if (model_drops < 65535)
      model_drops++;
    for (int i = 0; i < len; i++) begin
      w = $urandom;
      ni_q.push_back(w);
      if (match) exp_rxd.push_back((64'(i == len - 1) << 32) | 64'(w));
    end
  endtask

  task automatic wait_drain(input int budget);
    int n;
    int pending;
    n = 0;
    pending = 1;
    while (pending != 0 && n < budget) begin
      @(posedge clock);
      n++;
      pending = exp_net.size() + exp_rxh.size() + exp_rxd.size() + ni_q.size() + txd_q.size();
    end
    check_val("drain", 64'(pending), 64'd0);
  endtask

  initial begin
    int base, lbase, n;
    reset     = 1'b0;
    cmd_valid = 1'b0;
    cmd_dst_x = '0;
    cmd_dst_y = '0;
    cmd_len   = '0;
    cmd_tag   = '0;

    // Reset state
    repeat (2) @(negedge clock);
    check_val("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check_val("rst_net_i_ready", 64'(net_i_ready), 64'd1);
    check_val("rst_net_o_valid", 64'(net_o_valid), 64'd0);
    check_val("rst_txd_ready", 64'(txd_ready), 64'd0);
    check_val("rst_rxh_valid", 64'(rxh_valid), 64'd0);
    check_val("rst_rxd_valid", 64'(rxd_valid), 64'd0);
    check_val("rst_rxd_last", 64'(rxd_last), 64'd0);
    check_val("rst_net_o_dat", 64'(net_o_dat), 64'd0);
    check_val("rst_rxd_dat", 64'(rxd_dat), 64'd0);
    check_val("rst_rxh_fields", 64'({rxh_src_x, rxh_src_y, rxh_len, rxh_tag}), 64'd0);
    check_val("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    // TX header layout and payload order
    lbase = net_log.size();
    tx_pkt(3, 0, 2, 16'hBEEF, 2, 1'b1);
    n = 0;
    while (exp_net.size() > 0 && n < 200) begin
      @(posedge clock);
      n++;
    end
    @(negedge clock);
    check_val("tx_cmd_ready_back", 64'(cmd_ready), 64'd1);
    check_val("tx_flit_count", 64'(net_log.size() - lbase), 64'd3);
    check_val("tx_hdr_literal", 64'(log_at(lbase)), 64'h0000_0000_BEEF_0263);
    check_val("tx_word0", 64'(log_at(lbase + 1)), 64'h11);
    check_val("tx_word1", 64'(log_at(lbase + 2)), 64'h22);
    wait_drain(200);

    // Zero-length command held by backpressure
    o_ready_mode = 1;
    repeat (2) @(negedge clock);
    base = net_cnt;
    n = txd_cnt;
    tx_pkt(1, 3, 0, 16'h0F0F, 0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check_val("len0_hold_valid", 64'(net_o_valid), 64'd1);
      check_val("len0_hold_dat", 64'(net_o_dat), 64'(hdr_word(1, 3, MY_X, MY_Y, 0, 16'h0F0F)));
      check_val("len0_cmd_busy", 64'(cmd_ready), 64'd0);
    end
    o_ready_mode = 2;
    wait_drain(200);
    repeat (3) @(negedge clock);
    check_val("len0_one_flit", 64'(net_cnt - base), 64'd1);
    check_val("len0_no_txd", 64'(txd_cnt - n), 64'd0);

    // RX delivery with rxd_ready toggling
    rxd_mode = 3;
    n = rxd_cnt;
    base = rxd_last_cnt;
    rx_pkt(2, 1, 0, 0, 3, 16'h00AA);
    wait_drain(300);
    repeat (2) @(negedge clock);
    check_val("rx_words", 64'(rxd_cnt - n), 64'd3);
    check_val("rx_last_once", 64'(rxd_last_cnt - base), 64'd1);
    check_val("rx_hdr_literal", (rxh_log.size() > 0) ? rxh_log[rxh_log.size() - 1] : 'x, 64'h300AA);

    // Misrouted packet is swallowed and counted
    rxd_mode = 2;
    check_val("drop_pre", 64'(drop_cnt), 64'd0);
    rx_seen = 0;
    base = ni_cnt;
    rx_pkt(0, 0, 1, 1, 2, 16'h7777);
    wait_drain(200);
    repeat (2) @(negedge clock);
    check_val("drop_no_rx_valid", 64'(rx_seen), 64'd0);
    check_val("drop_flits_eaten", 64'(ni_cnt - base), 64'd3);
    check_val("drop_cnt_one", 64'(drop_cnt), 64'(model_drops));
    rx_pkt(2, 1, 3, 3, 2, 16'h1357);
    wait_drain(200);

    // Reset during TX payload
    base = net_cnt;
    tx_pkt(0, 2, 3, 16'h1234, 1, 1'b0);
    n = 0;
    while (net_cnt < base + 2 && n < 200) begin
      @(posedge clock);
      n++;
    end
    check_val("mid_rst_sent", 64'(net_cnt - base), 64'd2);
    @(negedge clock);
    #1 reset = 1'b0;
    #1;
    check_val("mid_rst_valid", 64'(net_o_valid), 64'd0);
    check_val("mid_rst_dat", 64'(net_o_dat), 64'd0);
    check_val("mid_rst_txd_ready", 64'(txd_ready), 64'd0);
    check_val("mid_rst_drop", 64'(drop_cnt), 64'd0);
    exp_net.delete();
    txd_q.delete();
    model_drops = 0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check_val("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);
    lbase = net_log.size();
    tx_pkt(1, 1, 1, 16'h5678, 1, 1'b0);
    wait_drain(200);
    check_val("post_rst_fresh_hdr", 64'(log_at(lbase)), 64'(hdr_word(1, 1, MY_X, MY_Y, 1, 16'h5678)));

    // Concurrent random TX and RX traffic
    o_ready_mode = 0;
    rxh_mode = 0;
    rxd_mode = 0;
    ni_gap = 30;
    td_gap = 30;
    fork
      begin
        int len;
        for (int k = 0; k < 20; k++) begin
          len = (k == 7) ? 255 : int'($urandom_range(8));
          tx_pkt(int'($urandom_range(3)), int'($urandom_range(3)), len,
                 int'($urandom_range(65535)), len, 1'b0);
          repeat ($urandom_range(2)) @(posedge clock);
        end
      end
      begin
        int len, dx, dy;
        for (int k = 0; k < 20; k++) begin
          len = (k == 5) ? 255 : int'($urandom_range(8));
          if (k == 5 || $urandom_range(3) != 0) begin
            dx = int'(MY_X);
            dy = int'(MY_Y);
          end else begin
            dx = int'($urandom_range(3));
            dy = int'($urandom_range(3));
          end
          rx_pkt(dx, dy, int'($urandom_range(3)), int'($urandom_range(3)), len,
                 int'($urandom_range(65535)));
          repeat ($urandom_range(4)) @(posedge clock);
        end
      end
    join
    wait_drain(6000);
    repeat (2) @(negedge clock);
    check_val("rand_drop_cnt", 64'(drop_cnt), 64'(model_drops));

    // Saturate the drop counter while TX keeps running
    ni_gap = 0;
    for (int k = 0; k < 65536; k++) rx_pkt(3, 3, 0, 0, 0, k & 16'hFFFF);
    fork
      begin
        int len;
        for (int k = 0; k < 4; k++) begin
          len = int'($urandom_range(1, 6));
          tx_pkt(int'($urandom_range(3)), int'($urandom_range(3)), len,
                 int'($urandom_range(65535)), len, 1'b0);
        end
      end
    join
    rx_pkt(2, 1, 2, 0, 4, 16'hCAFE);
    wait_drain(80000);
    repeat (2) @(negedge clock);
    check_val("drop_sat_model", 64'(drop_cnt), 64'(model_drops));
    check_val("drop_sat_ffff", 64'(drop_cnt), 64'hFFFF);
    check_val("final_tx_left", 64'(exp_net.size()), 64'd0);
    check_val("final_rx_left", 64'(exp_rxd.size() + exp_rxh.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
